// File: rtl/bean_reg_pkg.sv
// Shared register-port definitions: selector layout, register classes, access FSM states.
package bean_reg_pkg;

  localparam int BEAN_X_LEN       = 32;
  localparam int BEAN_REG_CLASS_W = 2;
  localparam int BEAN_REG_IDX_W   = 5;
  localparam int SEL_W            = BEAN_REG_CLASS_W + BEAN_REG_IDX_W;
  localparam int NUM_SRC          = 3;

  localparam logic [BEAN_REG_CLASS_W-1:0] REG_CLASS_X = 2'd0;
  localparam logic [BEAN_REG_CLASS_W-1:0] REG_CLASS_F = 2'd1;
  localparam logic [BEAN_REG_CLASS_W-1:0] REG_CLASS_I = 2'd2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  function automatic sel_t mk_sel(input logic [BEAN_REG_CLASS_W-1:0] cls,
                                  input logic [BEAN_REG_IDX_W-1:0] idx);
    return {cls, idx};
  endfunction

endpackage

// File: rtl/reg_access_ctrl_scoreboard.sv
// Pending-write scoreboard: one busy bit per register select, set on issue, cleared on writeback.
// Selector 0 (X0) is hard-wired not busy; a same-cycle set and clear of one select leaves it set.
module reg_scoreboard #(
  parameter int SEL_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_set_vld,
  input  logic [SEL_W-1:0]   i_set_sel,
  input  logic               i_clr_vld,
  input  logic [SEL_W-1:0]   i_clr_sel,
  input  logic [3*SEL_W-1:0] i_rs_sel,
  input  logic [SEL_W-1:0]   i_rd_sel,
  input  logic [SEL_W-1:0]   i_wb_sel,
  output logic [2:0]         o_rs_busy,
  output logic               o_rd_busy,
  output logic               o_wb_busy
);

  localparam int DEPTH = 1 << SEL_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_vld) begin
      w_busy_nxt[i_clr_sel] = 1'b0;
    end
    if (i_set_vld) begin
      w_busy_nxt[i_set_sel] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    o_rs_busy = '0;
    for (int i = 0; i < 3; i++) begin
      o_rs_busy[i] = r_busy[i_rs_sel[i*SEL_W +: SEL_W]];
    end
    o_rd_busy = r_busy[i_rd_sel];
    o_wb_busy = r_busy[i_wb_sel];
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-file initiator: hazard-checked operand reads to REG, operand bundle out, writebacks in.
// Optional forwarding of a same-cycle writeback into a blocked source read: macro RF_BYPASS_EN.
module reg_access_ctrl
  import bean_reg_pkg::*;
#(
  parameter int X_LEN       = BEAN_X_LEN,
  parameter int REG_CLASS_W = BEAN_REG_CLASS_W,
  parameter int REG_IDX_W   = BEAN_REG_IDX_W
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic [3*(REG_CLASS_W+REG_IDX_W)-1:0]    req_rs_sel,
  input  logic [2:0]                              req_rs_en,
  input  logic [REG_CLASS_W+REG_IDX_W-1:0]        req_rd_sel,
  input  logic                                    req_rd_en,
  output logic                                    op_valid,
  input  logic                                    op_ready,
  output logic [3*X_LEN-1:0]                      op_rs_data,
  output logic [REG_CLASS_W+REG_IDX_W-1:0]        op_rd_sel,
  input  logic                                    wb_valid,
  input  logic [REG_CLASS_W+REG_IDX_W-1:0]        wb_sel,
  input  logic [X_LEN-1:0]                        wb_data,
  output logic [3*(REG_CLASS_W+REG_IDX_W)-1:0]    rf_rs_sel,
  input  logic [3*X_LEN-1:0]                      rf_rs_data,
  output logic [REG_CLASS_W+REG_IDX_W-1:0]        rf_rd_sel,
  output logic [X_LEN-1:0]                        rf_rd_data,
  output logic                                    err
);

  localparam int SEL_BITS = REG_CLASS_W + REG_IDX_W;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3*SEL_BITS-1:0]   r_rs_sel_hold;
  logic [2:0]              r_rs_en;
  logic [SEL_BITS-1:0]     r_rd_sel_pend;
  logic [3*X_LEN-1:0]      r_op_rs_data;
  logic [SEL_BITS-1:0]     r_op_rd_sel;
  logic                    r_err;

  logic [2:0]              w_rs_busy;
  logic                    w_rd_busy;
  logic                    w_wb_busy;
  logic [2:0]              w_byp_hit;
  logic [2:0]              w_rs_blk;
  logic                    w_req_ready;
  logic                    w_accept;
  logic                    w_err_set;
  logic [3*X_LEN-1:0]      w_cap_data;

`ifdef RF_BYPASS_EN
  logic [2:0]              r_byp_hit;
  logic [X_LEN-1:0]        r_byp_data;
`endif

  reg_scoreboard #(
    .SEL_W (SEL_BITS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set_vld (w_accept & req_rd_en),
    .i_set_sel (req_rd_sel),
    .i_clr_vld (wb_valid),
    .i_clr_sel (wb_sel),
    .i_rs_sel  (req_rs_sel),
    .i_rd_sel  (req_rd_sel),
    .i_wb_sel  (wb_sel),
    .o_rs_busy (w_rs_busy),
    .o_rd_busy (w_rd_busy),
    .o_wb_busy (w_wb_busy)
  );

  // Hazard check uses registered busy bits only; forwarding can waive a source stall.
  always_comb begin
    w_byp_hit = '0;
    w_rs_blk  = '0;
    for (int i = 0; i < 3; i++) begin
`ifdef RF_BYPASS_EN
      w_byp_hit[i] = wb_valid & (wb_sel == req_rs_sel[i*SEL_BITS +: SEL_BITS])
                   & (wb_sel != '0);
`endif
      w_rs_blk[i] = req_rs_en[i] & w_rs_busy[i] & ~w_byp_hit[i];
    end
  end

  assign w_req_ready = rst_n & (r_state == ST_IDLE) & ~(|w_rs_blk) & ~(req_rd_en & w_rd_busy);
  assign w_accept    = req_valid & w_req_ready;
  assign w_err_set   = wb_valid & (wb_sel != '0) & ~w_wb_busy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_READ;
      ST_READ:  w_state_nxt = ST_VALID;
      ST_VALID: if (op_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_cap_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (r_rs_en[i]) begin
        w_cap_data[i*X_LEN +: X_LEN] = rf_rs_data[i*X_LEN +: X_LEN];
`ifdef RF_BYPASS_EN
        if (r_byp_hit[i]) begin
          w_cap_data[i*X_LEN +: X_LEN] = r_byp_data;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_sel_hold <= '0;
      r_rs_en       <= '0;
      r_rd_sel_pend <= '0;
      r_op_rs_data  <= '0;
      r_op_rd_sel   <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rs_sel_hold <= req_rs_sel;
        r_rs_en       <= req_rs_en;
        r_rd_sel_pend <= req_rd_sel;
      end
      if (r_state == ST_READ) begin
        r_op_rs_data <= w_cap_data;
        r_op_rd_sel  <= r_rd_sel_pend;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef RF_BYPASS_EN
  // REG returns the pre-write value when a read and write to one select share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp_hit  <= '0;
      r_byp_data <= '0;
    end else if (w_accept) begin
      r_byp_hit  <= w_byp_hit & req_rs_en;
      r_byp_data <= wb_data;
    end
  end
`endif

  assign req_ready  = w_req_ready;
  assign op_valid   = (r_state == ST_VALID);
  assign op_rs_data = r_op_rs_data;
  assign op_rd_sel  = r_op_rd_sel;
  assign err        = r_err;
  assign rf_rs_sel  = w_accept ? req_rs_sel : r_rs_sel_hold;
  // Idle cycles target X0 with zero so REG's unconditional write port is harmless.
  assign rf_rd_sel  = wb_valid ? wb_sel : '0;
  assign rf_rd_data = (wb_valid && (wb_sel != '0)) ? wb_data : '0;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: REG memory model, per-cycle behavioural reference and directed scenarios.
module tb_reg_access_ctrl;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [6:0] X0 = 7'd0;
  localparam logic [6:0] X5 = 7'd5;
  localparam logic [6:0] X6 = 7'd6;
  localparam logic [6:0] X7 = 7'd7;
  localparam logic [6:0] F3 = 7'h23;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [20:0] req_rs_sel;
  logic [2:0]  req_rs_en;
  logic [6:0]  req_rd_sel;
  logic        req_rd_en;
  logic        op_valid;
  logic        op_ready;
  logic [95:0] op_rs_data;
  logic [6:0]  op_rd_sel;
  logic        wb_valid;
  logic [6:0]  wb_sel;
  logic [31:0] wb_data;
  logic [20:0] rf_rs_sel;
  logic [95:0] rf_rs_data;
  logic [6:0]  rf_rd_sel;
  logic [31:0] rf_rd_data;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_access_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs_sel (req_rs_sel),
    .req_rs_en  (req_rs_en),
    .req_rd_sel (req_rd_sel),
    .req_rd_en  (req_rd_en),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_rs_data (op_rs_data),
    .op_rd_sel  (op_rd_sel),
    .wb_valid   (wb_valid),
    .wb_sel     (wb_sel),
    .wb_data    (wb_data),
    .rf_rs_sel  (rf_rs_sel),
    .rf_rs_data (rf_rs_data),
    .rf_rd_sel  (rf_rd_sel),
    .rf_rd_data (rf_rd_data),
    .err        (err)
  );

  // REG: registered reads, unconditional write every cycle.
  logic [31:0] mem [128];
  always @(posedge clk) begin
    rf_rs_data <= {mem[rf_rs_sel[20:14]], mem[rf_rs_sel[13:7]], mem[rf_rs_sel[6:0]]};
    mem[rf_rd_sel] <= rf_rd_data;
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents, pending-write set, one in-flight bundle.
  logic [31:0] m_regs [128];
  logic        m_busy [128];
  int          m_age;
  logic [95:0] m_pend, m_op;
  logic [6:0]  m_pend_rd, m_op_rd;
  logic [20:0] m_last;
  logic        m_err;
  logic        e_ready, e_acc, e_blk;
  logic [6:0]  e_s;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) m_busy[i] = 1'b0;
      m_age = -1; m_op = '0; m_op_rd = '0; m_last = '0; m_err = 1'b0;
      chk("rst_op_valid", op_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_op_rs_data", op_rs_data, 0);
      chk("rst_op_rd_sel", op_rd_sel, 0);
      chk("rst_err", err, 0);
    end else begin
      e_blk = 1'b0;
      for (int i = 0; i < 3; i++) begin
        e_s = req_rs_sel[i*7 +: 7];
        if (req_rs_en[i] && m_busy[e_s] && !(BYP && wb_valid && wb_sel == e_s)) e_blk = 1'b1;
      end
      e_ready = (m_age < 0) && !e_blk && !(req_rd_en && m_busy[req_rd_sel]);
      e_acc   = req_valid && e_ready;
      chk("m_req_ready", req_ready, e_ready);
      chk("m_op_valid", op_valid, m_age == 1);
      chk("m_op_rs_data", op_rs_data, m_op);
      chk("m_op_rd_sel", op_rd_sel, m_op_rd);
      chk("m_err", err, m_err);
      chk("m_rf_rs_sel", rf_rs_sel, e_acc ? req_rs_sel : m_last);
      chk("m_rf_rd_sel", rf_rd_sel, wb_valid ? wb_sel : 7'd0);
      chk("m_rf_rd_data", rf_rd_data, (wb_valid && wb_sel != 0) ? wb_data : 32'd0);
      if (e_acc) begin
        m_pend = '0;
        for (int i = 0; i < 3; i++) begin
          e_s = req_rs_sel[i*7 +: 7];
          if (req_rs_en[i])
            m_pend[i*32 +: 32] = (BYP && wb_valid && wb_sel == e_s && e_s != 0) ? wb_data : m_regs[e_s];
        end
        m_pend_rd = req_rd_sel;
        m_last    = req_rs_sel;
        m_age     = 0;
      end else if (m_age == 0) begin
        m_age = 1; m_op = m_pend; m_op_rd = m_pend_rd;
      end else if (m_age == 1 && op_ready) begin
        m_age = -1;
      end
      if (wb_valid) begin
        if (wb_sel != 0 && !m_busy[wb_sel]) m_err = 1'b1;
        m_regs[wb_sel] = (wb_sel == 0) ? 32'd0 : wb_data;
        m_busy[wb_sel] = 1'b0;
      end
      if (e_acc && req_rd_en && req_rd_sel != 0) m_busy[req_rd_sel] = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_op(input string nm, input logic [31:0] exp_rs1);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
      @(negedge clk);
      if (op_valid) begin
        got = 1'b1;
        chk(nm, op_rs_data[31:0], exp_rs1);
      end
    end
    chk({nm, "_arrived"}, got, 1'b1);
    step();
    op_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = 32'd0; m_regs[i] = 32'd0;
    end
    mem[5] = 32'h11; mem[6] = 32'h22; m_regs[5] = 32'h11; m_regs[6] = 32'h22;
    rst_n = 1'b0; req_valid = 1'b0; req_rs_sel = '0; req_rs_en = '0; req_rd_sel = '0;
    req_rd_en = 1'b0; op_ready = 1'b0; wb_valid = 1'b0; wb_sel = '0; wb_data = '0;
    repeat (3) step();
    step(); rst_n = 1'b1;
    // First read: rs1=X5, rs2=X6, rd=X7
    step();
    req_valid = 1'b1; req_rs_sel = {X0, X6, X5}; req_rs_en = 3'b011; req_rd_sel = X7; req_rd_en = 1'b1;
    @(negedge clk);
    chk("t1_ready", req_ready, 1'b1);
    chk("t1_rf_rs_sel", rf_rs_sel, {X0, X6, X5});
    step(); req_valid = 1'b0; req_rs_en = '0; req_rd_en = 1'b0;
    @(negedge clk);
    chk("t1_op_valid_t1", op_valid, 1'b0);
    step();
    @(negedge clk);
    chk("t1_op_valid_t2", op_valid, 1'b1);
    chk("t1_data", op_rs_data, {32'h0, 32'h22, 32'h11});
    chk("t1_rd_sel", op_rd_sel, X7);
    // Execute stalls while a request reading busy X7 waits
    for (int k = 0; k < 5; k++) begin
      step();
      req_valid = 1'b1; req_rs_sel = {X0, X0, X7}; req_rs_en = 3'b001; req_rd_en = 1'b0;
      @(negedge clk);
      chk("stall_valid", op_valid, 1'b1);
      chk("stall_data", op_rs_data, {32'h0, 32'h22, 32'h11});
      chk("stall_ready", req_ready, 1'b0);
    end
    step(); op_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", op_valid, 1'b1);
    step(); op_ready = 1'b0;
    @(negedge clk);
    chk("idle_x7_busy_ready", req_ready, 1'b0);
    chk("idle_op_valid", op_valid, 1'b0);
    step(); wb_valid = 1'b1; wb_sel = X7; wb_data = 32'hAB;
    @(negedge clk);
    chk("wb_cycle_ready", req_ready, BYP);
    chk("wb_rf_rd_sel", rf_rd_sel, X7);
    chk("wb_rf_rd_data", rf_rd_data, 32'hAB);
    step(); wb_valid = 1'b0;
    if (BYP) req_valid = 1'b0;
    @(negedge clk);
    chk("after_wb_ready", req_ready, !BYP);
    wait_op("raw_rs1", 32'hAB);
    chk("raw_err", err, 1'b0);
    // Unexpected writeback to F3, then to X0
    step(); wb_valid = 1'b1; wb_sel = F3; wb_data = 32'h5A;
    @(negedge clk);
    chk("f3_err_before", err, 1'b0);
    step(); wb_sel = X0; wb_data = 32'hFF;
    @(negedge clk);
    chk("f3_err_set", err, 1'b1);
    chk("f3_reg_written", mem[F3], 32'h5A);
    chk("x0_wb_data_zero", rf_rd_data, 32'h0);
    step(); wb_valid = 1'b0;
    @(negedge clk);
    chk("x0_err_unchanged", err, 1'b1);
    chk("idle_rf_rd_sel", rf_rd_sel, 7'd0);
    chk("idle_rf_rd_data", rf_rd_data, 32'd0);
    // Reset while in READ with X7 busy
    step(); req_valid = 1'b1; req_rs_en = 3'b000; req_rd_sel = X7; req_rd_en = 1'b1;
    @(negedge clk);
    chk("pre_rst_ready", req_ready, 1'b1);
    step(); req_valid = 1'b0; req_rd_en = 1'b0;
    @(negedge clk);
    chk("pre_rst_read_valid", op_valid, 1'b0);
    step(); rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_op_valid", op_valid, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    step(); rst_n = 1'b1;
    // rd == rs reads the old value
    step(); req_valid = 1'b1; req_rs_sel = {X0, X0, X7}; req_rs_en = 3'b001; req_rd_sel = X7; req_rd_en = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);
    wait_op("rd_eq_rs_rs1", 32'hAB);
    step(); req_rd_en = 1'b0; wb_valid = 1'b1; wb_sel = X7; wb_data = 32'h77;
    step(); wb_valid = 1'b0;
    @(negedge clk);
    chk("final_err", err, 1'b0);
    chk("final_reg_x7", mem[X7], 32'h77);
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
